// File: rtl/pc_unit_if.sv
// pc_unit_if: fetch-control bundle between the pipeline control logic and the
// program counter.
//   slave  : the program counter side. Its inputs are stall, imem_ready, the
//            redirect pulses (exc, jump_reg, jump, branch) and the redirect
//            operands (branch_target, jump_index, jr_target). Its outputs are
//            pc, pc_plus_4, fetch_valid and align_err.
//   master : the controlling side, with every direction reversed.
interface pc_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            stall;
  logic            imem_ready;
  logic            exc;
  logic            jump_reg;
  logic            jump;
  logic            branch;
  logic [XLEN-1:0] branch_target;
  logic [25:0]     jump_index;
  logic [XLEN-1:0] jr_target;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus_4;
  logic            fetch_valid;
  logic            align_err;

  modport slave (
    input  stall, imem_ready, exc, jump_reg, jump, branch,
           branch_target, jump_index, jr_target,
    output pc, pc_plus_4, fetch_valid, align_err
  );

  modport master (
    output stall, imem_ready, exc, jump_reg, jump, branch,
           branch_target, jump_index, jr_target,
    input  pc, pc_plus_4, fetch_valid, align_err
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: program counter at the head of IF. It drives the instruction-memory
// address, produces pc+4 and arbitrates the redirects. Priority is
// exc > jump_reg > jump > branch.
//
// A redirect that arrives while fetch cannot advance (stall=1 or imem_ready=0)
// is held in a one-entry pending register. It is applied on the next advance.
// A pending exception cannot be displaced by a later non-exception redirect.
// While a redirect is pending, fetch_valid is low so that IF/ID squashes the
// wrong-path fetch.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    pc_unit_if.slave, which carries these signals:
//          stall, imem_ready, the redirect pulses and their targets (inputs);
//          pc, pc_plus_4, fetch_valid, align_err (outputs).
//
// Optional build macro PC_ALIGN_CHECK_EN:
//   When defined, a jr/jalr target whose low bits are nonzero becomes an
//   exception redirect to EXC_VECTOR, and align_err pulses for one cycle.
//   When undefined, the low bits of the target are forced to 00 and align_err
//   stays 0.
module pc_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [31:0]     EXC_VECTOR   = 32'h8000_0180,
  parameter int unsigned     JUMP_MODE    = 0
) (
  input  logic      clk,
  input  logic      rst_n,
  pc_unit_if.slave  bus
);

  localparam logic [XLEN-1:0] EXC_TARGET = XLEN'(EXC_VECTOR);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_plus_4;
  logic [XLEN-1:0] pend_addr;
  logic            pend_valid;
  logic            pend_exc;
  logic            started;

  logic            advance;
  logic [XLEN-1:0] jump_tgt;
  logic [XLEN-1:0] jr_tgt;
  logic            new_valid;
  logic            new_exc;
  logic [XLEN-1:0] new_tgt;
  logic            new_accept;

  assign pc_plus_4 = pc_q + XLEN'(4);
  assign advance   = ~bus.stall & bus.imem_ready;
  assign jr_tgt    = {bus.jr_target[XLEN-1:2], 2'b00};

  generate
    if (JUMP_MODE == 0) begin : g_jump_arch
      assign jump_tgt = {pc_plus_4[XLEN-1:28], bus.jump_index, 2'b00};
    end else begin : g_jump_legacy
      assign jump_tgt = {pc_plus_4[XLEN-1:28], 6'b0, bus.jump_index[19:0], 2'b00};
    end
  endgenerate

`ifdef PC_ALIGN_CHECK_EN
  logic new_conv;
`endif

  // Pick the single winning redirect for this cycle.
  always_comb begin
    new_valid = 1'b0;
    new_exc   = 1'b0;
    new_tgt   = '0;
`ifdef PC_ALIGN_CHECK_EN
    new_conv  = 1'b0;
`endif
    if (bus.exc) begin
      new_valid = 1'b1;
      new_exc   = 1'b1;
      new_tgt   = EXC_TARGET;
    end else if (bus.jump_reg) begin
      new_valid = 1'b1;
      new_tgt   = jr_tgt;
`ifdef PC_ALIGN_CHECK_EN
      if (|bus.jr_target[1:0]) begin
        new_exc  = 1'b1;
        new_conv = 1'b1;
        new_tgt  = EXC_TARGET;
      end
`endif
    end else if (bus.jump) begin
      new_valid = 1'b1;
      new_tgt   = jump_tgt;
    end else if (bus.branch) begin
      new_valid = 1'b1;
      new_tgt   = bus.branch_target;
    end
  end

  // A pending exception outranks any later non-exception redirect. This holds
  // both when the pc is loaded and when the pending entry would be overwritten.
  assign new_accept = new_valid & ~(pend_exc & ~new_exc);

  // When a new redirect is blocked by a pending exception, control falls
  // through to the pending branch below. That load is correct because
  // pend_exc implies pend_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_VECTOR;
      pend_addr  <= '0;
      pend_valid <= 1'b0;
      pend_exc   <= 1'b0;
      started    <= 1'b0;
    end else begin
      started <= 1'b1;
      if (advance) begin
        if (new_accept) begin
          pc_q <= new_tgt;
        end else if (pend_valid) begin
          pc_q <= pend_addr;
        end else begin
          pc_q <= pc_plus_4;
        end
        pend_valid <= 1'b0;
        pend_exc   <= 1'b0;
      end else if (new_accept) begin
        pend_addr  <= new_tgt;
        pend_valid <= 1'b1;
        pend_exc   <= new_exc;
      end
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  // A converted redirect is always accepted: it is an exception, so no
  // pending entry can block it.
  logic align_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      align_q <= 1'b0;
    end else begin
      align_q <= new_conv;
    end
  end
  assign bus.align_err = align_q;
`else
  assign bus.align_err = 1'b0;
`endif

  assign bus.pc          = pc_q;
  assign bus.pc_plus_4   = pc_plus_4;
  assign bus.fetch_valid = started & ~pend_valid;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: bench for pc_unit with a scoreboard.
// Two instances share one set of stimulus:
//   dut0 uses JUMP_MODE=0 and RESET_VECTOR=0.
//   dut1 uses JUMP_MODE=1 and RESET_VECTOR=0x0040_0000.
// Each cycle, a reference model derives the expected outputs from the
// redirect rules and pushes them onto a queue. A monitor pops one entry after
// each rising edge and compares it with both instances.
// Directed sequences run first, followed by randomized traffic.
module tb_pc_unit;

  localparam logic [31:0] EXC = 32'h8000_0180;
  localparam logic [31:0] RV1 = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, imem_ready, exc, jump_reg, jump, branch;
  logic [31:0] branch_target, jr_target;
  logic [25:0] jump_index;

  always #5 clk = ~clk;

  pc_unit_if #(.XLEN(32)) if0 ();
  pc_unit_if #(.XLEN(32)) if1 ();

  assign if0.stall = stall;          assign if1.stall = stall;
  assign if0.imem_ready = imem_ready; assign if1.imem_ready = imem_ready;
  assign if0.exc = exc;              assign if1.exc = exc;
  assign if0.jump_reg = jump_reg;    assign if1.jump_reg = jump_reg;
  assign if0.jump = jump;            assign if1.jump = jump;
  assign if0.branch = branch;        assign if1.branch = branch;
  assign if0.branch_target = branch_target; assign if1.branch_target = branch_target;
  assign if0.jump_index = jump_index; assign if1.jump_index = jump_index;
  assign if0.jr_target = jr_target;  assign if1.jr_target = jr_target;

  pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .EXC_VECTOR(EXC), .JUMP_MODE(0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  pc_unit #(.XLEN(32), .RESET_VECTOR(RV1), .EXC_VECTOR(EXC), .JUMP_MODE(1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  // Architectural state of the reference model.
  typedef struct packed {
    logic [31:0] pc;
    logic        pend_v;
    logic        pend_exc;
    logic [31:0] pend_addr;
    logic        started;
    logic        ae;
  } mst_t;

  typedef struct packed {
    logic [31:0] pc0; logic fv0; logic ae0;
    logic [31:0] pc1; logic fv1; logic ae1;
  } exp_t;

  mst_t m0, m1;
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Advance the model by one clock edge, using the inputs currently driven.
  function automatic mst_t model_step(mst_t s, int unsigned jmode, logic [31:0] rv);
    mst_t        n;
    logic [31:0] seq;
    logic [31:0] tgt;
    logic [31:0] addr;
    bit          win, win_exc, conv, have, is_exc, adv;
    n       = s;
    n.ae    = 1'b0;
    seq     = s.pc + 32'd4;
    tgt     = '0;
    win     = 0;
    win_exc = 0;
    conv    = 0;
    adv     = !stall && imem_ready;
    if (!rst_n) begin
      n    = '0;
      n.pc = rv;
      return n;
    end
    if (exc) begin
      win = 1; win_exc = 1; tgt = EXC;
    end else if (jump_reg) begin
      win = 1; tgt = jr_target & 32'hFFFF_FFFC;
`ifdef PC_ALIGN_CHECK_EN
      if (jr_target % 4 != 0) begin win_exc = 1; conv = 1; tgt = EXC; end
`endif
    end else if (jump) begin
      win = 1;
      if (jmode == 0) tgt = (seq & 32'hF000_0000) | (32'(jump_index) * 4);
      else            tgt = (seq & 32'hF000_0000) | ((32'(jump_index) % 32'h10_0000) * 4);
    end else if (branch) begin
      win = 1; tgt = branch_target;
    end
    // The surviving redirect is the pending one, unless the new one may replace it.
    have = s.pend_v; addr = s.pend_addr; is_exc = s.pend_exc;
    if (win && !(is_exc && !win_exc)) begin
      have = 1; addr = tgt; is_exc = win_exc;
    end
    if (adv) begin
      n.pc = have ? addr : seq;
      n.pend_v = 0; n.pend_exc = 0;
    end else begin
      n.pend_v = have; n.pend_addr = addr; n.pend_exc = is_exc;
    end
    n.ae      = conv;
    n.started = 1;
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic clr();
    exc = 0; jump_reg = 0; jump = 0; branch = 0;
  endtask

  // Push the expected result of the coming edge, then move to the next falling edge.
  task automatic tick();
    exp_t e;
    m0 = model_step(m0, 0, 32'h0);
    m1 = model_step(m1, 1, RV1);
    e.pc0 = m0.pc; e.fv0 = m0.started & ~m0.pend_v; e.ae0 = m0.ae;
    e.pc1 = m1.pc; e.fv1 = m1.started & ~m1.pend_v; e.ae1 = m1.ae;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: one scoreboard entry is checked after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc0",  if0.pc, e.pc0);
        chk("pc4_0", if0.pc_plus_4, e.pc0 + 32'd4);
        chk("fv0",  32'(if0.fetch_valid), 32'(e.fv0));
        chk("ae0",  32'(if0.align_err), 32'(e.ae0));
        chk("pc1",  if1.pc, e.pc1);
        chk("pc4_1", if1.pc_plus_4, e.pc1 + 32'd4);
        chk("fv1",  32'(if1.fetch_valid), 32'(e.fv1));
        chk("ae1",  32'(if1.align_err), 32'(e.ae1));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    m0 = '0; m1 = '0;
    rst_n = 0; stall = 0; imem_ready = 1;
    branch_target = '0; jr_target = '0; jump_index = '0;
    clr();
    // Reset, then sequential fetch.
    tick(); tick();
    rst_n = 1;
    repeat (4) tick();
    // A simultaneous jump and branch: the jump wins. Run with both jump_index values.
    branch = 1; branch_target = 32'h0040_0010; tick(); clr();
    branch = 1; branch_target = 32'h0040_0100; jump = 1; jump_index = 26'h000_0040;
    tick(); clr(); tick();
    branch = 1; branch_target = 32'h0040_0010; tick(); clr();
    branch = 1; branch_target = 32'h0040_0100; jump = 1; jump_index = 26'h3F0_0040;
    tick(); clr(); tick();
    // A branch arrives during a three-cycle stall.
    stall = 1; branch = 1; branch_target = 32'h200; tick(); clr();
    tick(); tick();
    stall = 0; tick(); tick();
    // While memory is not ready: jr, then exc, then branch. The exception must win.
    imem_ready = 0; jump_reg = 1; jr_target = 32'h300; tick(); clr();
    exc = 1; tick(); clr();
    branch = 1; branch_target = 32'h444; tick(); clr();
    tick();
    imem_ready = 1; tick(); tick();
    // pc wraps from 0xFFFF_FFFC to 0.
    branch = 1; branch_target = 32'hFFFF_FFFC; tick(); clr(); tick(); tick();
    // A misaligned jr target, while advancing.
    jump_reg = 1; jr_target = 32'h1002; tick(); clr(); tick(); tick();
    // A misaligned jr during a stall, followed by a branch that must not displace it.
    stall = 1; jump_reg = 1; jr_target = 32'h2001; tick(); clr();
    branch = 1; branch_target = 32'h500; tick(); clr();
    stall = 0; tick(); tick();
    // Reset while a redirect is pending drops the pending redirect.
    imem_ready = 0; branch = 1; branch_target = 32'h700; tick(); clr();
    rst_n = 0; tick();
    rst_n = 1; imem_ready = 1; tick(); tick();
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      stall         = ($urandom_range(0, 3) == 0);
      imem_ready    = ($urandom_range(0, 4) != 0);
      exc           = ($urandom_range(0, 15) == 0);
      jump_reg      = ($urandom_range(0, 7) == 0);
      jump          = ($urandom_range(0, 7) == 0);
      branch        = ($urandom_range(0, 5) == 0);
      branch_target = $urandom;
      jump_index    = 26'($urandom);
      jr_target     = ($urandom_range(0, 1) == 0) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
      rst_n         = ($urandom_range(0, 199) != 0);
      tick();
    end
    clr(); rst_n = 1;
    @(posedge clk);
    #2;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised next-generation program counter for the pipelined MIPS core; sits at the head of IF and drives the instruction-memory address.
- Generates PC+4 internally and arbitrates redirects from exception, jr, j/jal and branch.
- Buffers a redirect that arrives while fetch cannot advance, then applies it on the next advance.
- Marks wrong-path fetches invalid, so IF/ID can squash them.

Parameters:
XLEN, 32, PC/datapath width; legal values 32 or 64.
RESET_VECTOR, 0, PC value loaded on reset.
EXC_VECTOR, 32'h8000_0180, exception handler entry (zero-extended to XLEN).
JUMP_MODE, 0, 0 = architectural {pc_plus_4[XLEN-1:28], jump_index, 2'b00}; 1 = legacy {pc_plus_4[XLEN-1:28], 6'b0, jump_index[19:0], 2'b00}.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
stall  input  1  hazard-unit freeze of IF.
imem_ready  input  1  instruction memory accepts the current address this cycle.
exc  input  1  exception redirect pulse.
jump_reg  input  1  jr/jalr redirect pulse.
jump  input  1  j/jal redirect pulse.
branch  input  1  taken-branch redirect pulse.
branch_target  input  XLEN  PC+4+(imm<<2), computed in ID/EX.
jump_index  input  26  instr[25:0].
jr_target  input  XLEN  register-file operand.
pc  output  XLEN  current fetch address.
pc_plus_4  output  XLEN  pc + 4, modulo 2^XLEN.
fetch_valid  output  1  instruction fetched at pc is on the correct path.
align_err  output  1  misaligned jr target, one-cycle pulse (optional feature only).

Behaviour:
- Reset (rst_n low, async):
  - pc = RESET_VECTOR.
  - pend_valid = 0, pend_exc = 0, started = 0.
  - fetch_valid = 0, align_err = 0.
- started:
  - Set on the first clk edge after rst_n rises.
  - fetch_valid = started & ~pend_valid.
- advance = ~stall & imem_ready.
- Redirect targets:
  - exc → EXC_VECTOR.
  - jump_reg → jr_target with bits [1:0] forced to 00.
  - jump → per JUMP_MODE.
  - branch → branch_target.
- New-redirect priority, when several sources assert in the same cycle: exc > jump_reg > jump > branch. Only the winner is considered.
- Each redirect input is a single-cycle pulse. The block never requires it to be held.
- Next-state selection on each clk edge:
  1. advance=1 with a new redirect: pc <= new target, with one exception. If pend_exc=1 and the new redirect is not exc, pc <= pend_addr. Clear pend.
  2. advance=1, no new redirect, pend_valid=1: pc <= pend_addr; clear pend.
  3. advance=1, nothing pending: pc <= pc + 4. Wrap from 2^XLEN-4 to 0 is silent.
  4. advance=0 with a new redirect:
     - Latch the target into pend_addr and set pend_valid; set pend_exc if the source is exc.
     - A new redirect overwrites an existing pend, except that a non-exc redirect never overwrites pend_exc=1.
  5. advance=0, no new redirect: hold pc and pend.
- pc_plus_4 is combinational from pc.
- jump composition uses pc_plus_4 of the current pc.
- Redirect latency: the target appears on pc one edge after the redirect pulse when advance=1. Otherwise it appears on the first edge where advance=1.
- A reset asserted mid-pend discards the pending redirect.

Optional Feature:
PC_ALIGN_CHECK_EN
- Defined:
  - When jump_reg wins and jr_target[1:0] != 0, the redirect is converted to an exception: target = EXC_VECTOR, treated as exc for pend priority.
  - align_err pulses high for one cycle, on the edge the conversion is accepted (pc updated or pend latched).
- Undefined:
  - Low bits are silently forced to 00.
  - align_err is tied 0.

Test Plan:
- Reset, RESET_VECTOR=0, advance held 1 → fetch_valid=0 in reset; pc=0 during reset; then 0, 4, 8, 12 on successive edges; fetch_valid=1 from the first edge after release.
- pc=0x0040_0010; branch=1 with branch_target=0x0040_0100 simultaneously with jump=1, jump_index=0x000_0040, JUMP_MODE=0 → pc=0x0000_0100 (jump wins). Repeat with JUMP_MODE=1 and jump_index=0x3F0_0040 → pc=0x0000_0100.
- stall=1 for 3 cycles; branch pulse to 0x200 in cycle 1 → pc frozen; fetch_valid=0 while pending; on stall release pc=0x200, then 0x204.
- imem_ready=0; jump_reg to 0x300 latched, then exc pulse next cycle, then branch pulse → on ready pc=EXC_VECTOR (0x8000_0180); branch ignored.
- XLEN=32, pc=0xFFFF_FFFC, advance → pc=0x0000_0000, no flag.
- PC_ALIGN_CHECK_EN defined, jr_target=0x1002 → pc=0x8000_0180 and align_err=1 for one cycle. Without the macro → pc=0x1000, align_err=0.
